dmem_store_buffer: RTL and testbench
====================================

# dmem_store_buffer

Posted-write store buffer between the single-cycle CPU datapath's data-memory outputs (ALU result address, store data, write enable) and a slower data RAM. Stores retire in one CPU cycle into a small FIFO and drain to RAM over a req/ack handshake. Loads read RAM combinationally, with youngest-match forwarding from the buffer. The CPU holds its PC while `stall` is high.

## Interface
Parameters:
- `DEPTH`, 4, number of buffer entries (power of two, ≥2)

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `cpu_addr`  in  32  byte address from ALU result
- `cpu_wdata`  in  32  store data from register file
- `cpu_wmem`  in  1  store request this cycle
- `cpu_rmem`  in  1  load request this cycle (mem-to-reg select)
- `cpu_rdata`  out  32  load data to CPU, combinational
- `stall`  out  1  CPU must not advance PC this cycle, combinational
- `sb_empty`  out  1  buffer holds no entries, registered
- `mem_raddr`  out  32  RAM async read address, equals `{cpu_addr[31:2],2'b00}`
- `mem_rdata`  in  32  RAM async read data
- `mem_req`  out  1  write request, registered
- `mem_waddr`  out  32  write word address (head entry, low 2 bits zero)
- `mem_wdata`  out  32  write data (head entry)
- `mem_ack`  in  1  write accepted, sampled on rising edge only while `mem_req`=1

## Operation
- Entry = {word address `addr[31:2]`, 32-bit data}. Circular FIFO, head/tail pointers, count 0..DEPTH.
- Full = count==DEPTH. `stall` = `cpu_wmem` & full. Stall holds even if `mem_ack` pops in the same cycle.
- Enqueue at the edge when `cpu_wmem` & ~`stall`. Enqueue and pop may occur at the same edge; count is unchanged.
- Byte offset `cpu_addr[1:0]` is ignored. Stores are always full-word.
- Load forwarding: when `cpu_rmem`=1 and ~`cpu_wmem`, `cpu_rdata` is the data of the youngest valid entry whose word address matches. With no match, it is `mem_rdata`. The head entry is included even while in flight.
- A store enqueued at edge t is visible to forwarding from cycle t onward.
- If `cpu_wmem` and `cpu_rmem` are both 1, the store wins and `cpu_rdata` is don't-care.
- Drain FSM:
  - States are IDLE and BUSY.
  - IDLE → BUSY when count>0. `mem_req` becomes 1 with that transition.
  - In BUSY, `mem_req`=1 and `mem_waddr`/`mem_wdata` stay stable at the head entry until `mem_ack`.
  - On `mem_ack` in BUSY, the head pops. If post-pop count>0, the FSM stays BUSY and presents the next head on the following cycle with no idle gap. Otherwise it returns to IDLE and `mem_req` falls.
- `mem_ack` while `mem_req`=0 is ignored.
- Reset mid-operation:
  - Buffered stores are discarded.
  - FSM goes to IDLE and `mem_req` drops immediately (async).
  - The RAM must treat a withdrawn request as abandoned.

## Timing
- Reset values: `mem_req`=0, `sb_empty`=1, `mem_waddr`=0, `mem_wdata`=0, count=0, FSM=IDLE. `stall` reads 0 (buffer not full). `cpu_rdata` follows `mem_rdata`.
- A store at edge t (IDLE, empty) drives `mem_req`=1 after edge t+1.
- With `mem_ack` high at edge t+k, the entry is gone after edge t+k, and `sb_empty`=1 after t+k if it was the last entry.
- Back-to-back drain with ack asserted every cycle: one entry per cycle.
- `stall` and `cpu_rdata` have no register stage; they have a combinational path from `cpu_*` and the buffer state.

## Configuration
- `STBUF_COALESCE_EN` defined:
  - A store whose word address matches a valid entry other than the in-flight head overwrites the youngest such entry in place. No allocation occurs.
  - Such a store does not stall even when full.
- Not defined: every store allocates a new entry, and duplicates are drained in order.

## Test plan
- Reset, then store 0x11223344 to 0x100, with `mem_ack` tied 1.
  - `mem_req`=1 one cycle after the store, `mem_waddr`=0x100, `mem_wdata`=0x11223344.
  - Pop follows, then `sb_empty`=1.
- `mem_ack`=0, issue 5 stores to 0x0,0x4,0x8,0xC,0x10.
  - `stall`=1 on the 5th until an ack frees a slot.
  - RAM receives writes in order 0x0..0x10.
- `mem_ack`=0, store 0xAAAA to 0x20, then 0xBBBB to 0x20, then load 0x22 → `cpu_rdata`=0xBBBB.
  - Load 0x24 with RAM holding 0x5555 → `cpu_rdata`=0x5555.
- Assert `reset` while BUSY with 3 entries → `mem_req`=0 and `sb_empty`=1 immediately, with no further writes.
- With `STBUF_COALESCE_EN`, `mem_ack`=0, stores 0x1 to 0x40, 0x2 to 0x44, 0x3 to 0x44.
  - Count is 2, and RAM finally sees 0x44=0x3.
  - Without the macro, count is 3 and RAM sees 0x44=0x2 then 0x3.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write FIFO between the CPU data port and a slow RAM, with youngest-match load forwarding.
// Define STBUF_COALESCE_EN to merge stores into matching pending (not in-flight) entries.
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_wmem,
  input  logic        cpu_rmem,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        sb_empty,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack
);
  localparam int AW = $clog2(DEPTH);
`ifdef STBUF_COALESCE_EN
  localparam logic COAL = 1'b1;
`else
  localparam logic COAL = 1'b0;
`endif
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        r_state, w_state_nxt;
  logic [29:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_head, r_tail, w_idx, w_co_idx;
  logic [AW:0]   r_count, w_count_nxt;
  logic [31:0]   w_fwd_data;
  logic          w_co_hit, w_coal, w_push, w_pop, w_unused_lo;
  // Walk oldest to youngest so the last match is the youngest one.
  always_comb begin
    w_idx = r_head;
    w_fwd_data = mem_rdata;
    w_co_hit = 1'b0;
    w_co_idx = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + AW'(i);
      if ((AW+1)'(i) < r_count && r_addr[w_idx] == cpu_addr[31:2]) begin
        w_fwd_data = r_data[w_idx];
        if (!(i == 0 && r_state == BUSY)) begin
          w_co_hit = 1'b1;
          w_co_idx = w_idx;
        end
      end
    end
  end
  assign w_coal      = COAL & cpu_wmem & w_co_hit;
  assign stall       = cpu_wmem & (r_count == (AW+1)'(DEPTH)) & ~w_coal;
  assign w_push      = cpu_wmem & ~stall & ~w_coal;
  assign w_pop       = (r_state == BUSY) & mem_ack;
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign cpu_rdata   = (cpu_rmem & ~cpu_wmem) ? w_fwd_data : mem_rdata;
  assign mem_raddr   = {cpu_addr[31:2], 2'b00};
  assign mem_waddr   = {r_addr[r_head], 2'b00};
  assign mem_wdata   = r_data[r_head];
  assign mem_req     = (r_state == BUSY);
  assign sb_empty    = (r_count == '0);
  assign w_unused_lo = &{1'b0, cpu_addr[1:0]};
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == IDLE) ? ((r_count != '0) ? BUSY : IDLE)
                                    : ((w_pop && w_count_nxt == '0) ? IDLE : BUSY);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) begin
        r_addr[r_tail] <= cpu_addr[31:2];
        r_data[r_tail] <= cpu_wdata;
        r_tail         <= r_tail + AW'(1);
      end
      if (w_coal) r_data[w_co_idx] <= cpu_wdata;
      if (w_pop) r_head <= r_head + AW'(1);
    end
  end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed and random stores/loads against a queue-based model; a negedge monitor scores RAM writes.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;
`ifdef STBUF_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif
  logic        clock = 1'b0, reset = 1'b1;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
  logic        cpu_wmem = 1'b0, cpu_rmem = 1'b0, mem_ack = 1'b0;
  logic [31:0] cpu_rdata, mem_raddr, mem_waddr, mem_wdata;
  logic        stall, sb_empty, mem_req;

  dmem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wmem(cpu_wmem), .cpu_rmem(cpu_rmem), .cpu_rdata(cpu_rdata), .stall(stall),
    .sb_empty(sb_empty), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_req(mem_req),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    int          id;
  } ent_t;

  ent_t mq[$];
  ent_t exp_q[$];
  ent_t mon_e;
  bit   busy;
  int   next_id, n_cmp, n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h expected no write at %0t", mem_waddr, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", mem_waddr, {mon_e.a, 2'b00});
        chk("wr_data", mem_wdata, mon_e.d);
      end
    end
  end

  // Called 1 time unit after a rising edge; returns one time unit after the next one.
  task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic ack, input logic [31:0] rd, output logic stalled);
    int j, n0;
    logic [31:0] fwd;
    logic coal, pop;
    ent_t e;
    cpu_wmem = w; cpu_rmem = r; cpu_addr = a; cpu_wdata = d; mem_ack = ack; mem_rdata = rd;
    j = -1;
    fwd = rd;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].a == a[31:2]) begin
        fwd = mq[i].d;
        if (COAL && !(i == 0 && busy)) j = i;
      end
    coal = w && (j >= 0);
    stalled = w && (mq.size() == DEPTH) && !coal;
    #2;
    chk("stall", {31'b0, stall}, {31'b0, stalled});
    chk("mem_req", {31'b0, mem_req}, {31'b0, busy});
    chk("sb_empty", {31'b0, sb_empty}, {31'b0, mq.size() == 0});
    chk("mem_raddr", mem_raddr, {a[31:2], 2'b00});
    if (r && !w) chk("cpu_rdata", cpu_rdata, fwd);
    @(posedge clock);
    pop = busy && ack;
    n0 = mq.size();
    if (coal) begin
      mq[j].d = d;
      foreach (exp_q[k]) if (exp_q[k].id == mq[j].id) exp_q[k].d = d;
    end else if (w && !stalled) begin
      e = '{a[31:2], d, next_id};
      next_id++;
      mq.push_back(e);
      exp_q.push_back(e);
    end
    if (pop) mq.delete(0);
    busy = busy ? (mq.size() > 0) : (n0 > 0);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic ack);
    logic st;
    step(1'b1, 1'b0, a, d, ack, $urandom, st);
    for (int k = 0; k < 20 && st; k++) step(1'b1, 1'b0, a, d, (k > 0) ? 1'b1 : ack, $urandom, st);
  endtask

  task automatic idle(input logic ack, input int n);
    logic st;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, ack, $urandom, st);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] rd);
    logic st;
    step(1'b0, 1'b1, a, '0, 1'b0, rd, st);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (mq.size() > 0 || busy); k++) idle(1'b1, 1);
    chk("drain_left", mq.size(), 0);
    idle(1'b1, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_wmem = 1'b0;
    cpu_rmem = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
    mq.delete();
    exp_q.delete();
    busy = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic st;
    @(posedge clock);
    #1;
    mem_rdata = 32'hCAFE_F00D;
    cpu_rmem = 1'b1;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'hCAFE_F00D);
    @(posedge clock);
    #1;
    reset = 1'b0;
    store(32'h100, 32'h1122_3344, 1'b1);
    idle(1'b1, 4);
    drain();
    for (int i = 0; i < 5; i++) store(32'(i * 4), 32'hD000_0000 + 32'(i), 1'b0);
    drain();
    store(32'h20, 32'hAAAA, 1'b0);
    store(32'h20, 32'hBBBB, 1'b0);
    load(32'h22, 32'h1234_5678);
    load(32'h24, 32'h5555);
    drain();
    store(32'h200, 32'h1, 1'b0);
    store(32'h204, 32'h2, 1'b0);
    store(32'h208, 32'h3, 1'b0);
    idle(1'b0, 1);
    do_reset();
    idle(1'b1, 5);
    store(32'h40, 32'h1, 1'b0);
    store(32'h44, 32'h2, 1'b0);
    store(32'h44, 32'h3, 1'b0);
    load(32'h44, 32'h0);
    drain();
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)), $urandom,
           $urandom_range(0, 2) == 0, $urandom, st);
    drain();
    chk("exp_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
